// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame marker, widths
// common with the processor, loader state encoding and the checksum helper.
package imem_loader_pkg;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_AHI  = 4'd1,
    ST_ALO  = 4'd2,
    ST_CHI  = 4'd3,
    ST_CLO  = 4'd4,
    ST_DHI  = 4'd5,
    ST_DLO  = 4'd6,
    ST_CSUM = 4'd7,
    ST_DONE = 4'd8,
    ST_ERR  = 4'd9
  } state_t;

  // Running frame checksum: 8-bit sum of data bytes, wrapping mod 256.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/imem_loader_wr.sv
// Registered instruction-memory write stage: owns the word address pointer,
// issues one-cycle write strobes and advances the address with 16-bit wrap.
module imem_loader_wr
  import imem_loader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          addr_load,
  input  logic [AW-1:0] addr_val,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata
);

  logic [AW-1:0] addr_r;

  // Address pointer and registered write port; reset cancels any pending strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= {AW{1'b0}};
      we     <= 1'b0;
      waddr  <= {AW{1'b0}};
      wdata  <= {DW{1'b0}};
    end else begin
      we <= wr_req;
      if (addr_load) begin
        addr_r <= addr_val;
      end else if (wr_req) begin
        addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
        waddr  <= addr_r;
        wdata  <= wr_data;
      end else begin
        addr_r <= addr_r;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 16-bit instruction memory. Parses the frame,
// checks the data checksum and holds the processor in reset until a good frame.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  state_t        state_r;
  logic [7:0]    addr_hi_r;
  logic [7:0]    cnt_hi_r;
  logic [7:0]    hi_r;
  logic [7:0]    sum_r;
  logic [15:0]   remain_r;

  logic          acc_s;
  logic          addr_load_s;
  logic          wr_req_s;
  logic [AW-1:0] addr_val_s;
  logic [DW-1:0] wr_data_s;
  logic [15:0]   cnt_s;

  // Byte acceptance and the requests handed to the write stage.
  always_comb begin
    acc_s       = in_valid && in_ready;
    addr_load_s = acc_s && (state_r == ST_ALO);
    wr_req_s    = acc_s && (state_r == ST_DLO);
    addr_val_s  = {addr_hi_r, in_data};
    wr_data_s   = {hi_r, in_data};
    cnt_s       = {cnt_hi_r, in_data};
  end

  // Frame parser FSM with checksum accumulation and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      addr_hi_r <= 8'h00;
      cnt_hi_r  <= 8'h00;
      hi_r      <= 8'h00;
      sum_r     <= 8'h00;
      remain_r  <= 16'h0000;
      in_ready  <= 1'b1;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (acc_s) begin
      case (state_r)
        ST_IDLE: begin
          if (in_data == MAGIC) begin
            state_r <= ST_AHI;
            sum_r   <= 8'h00;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_AHI: begin
          addr_hi_r <= in_data;
          state_r   <= ST_ALO;
        end
        ST_ALO: state_r <= ST_CHI;
        ST_CHI: begin
          cnt_hi_r <= in_data;
          state_r  <= ST_CLO;
        end
        ST_CLO: begin
          remain_r <= cnt_s;
          if (cnt_s == 16'h0000) begin
            state_r <= ST_CSUM;
          end else begin
            state_r <= ST_DHI;
          end
        end
        ST_DHI: begin
          hi_r    <= in_data;
          sum_r   <= csum_add(sum_r, in_data);
          state_r <= ST_DLO;
        end
        ST_DLO: begin
          sum_r    <= csum_add(sum_r, in_data);
          remain_r <= remain_r - 16'h0001;
          if (remain_r == 16'h0001) begin
            state_r <= ST_CSUM;
          end else begin
            state_r <= ST_DHI;
          end
        end
        ST_CSUM: begin
          in_ready <= 1'b0;
          if (in_data == sum_r) begin
            state_r  <= ST_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state_r  <= ST_ERR;
            err      <= 1'b1;
            cpu_hold <= 1'b1;
          end
        end
        // Terminal states: in_ready is low, so nothing is accepted until reset.
        ST_DONE: state_r <= ST_DONE;
        ST_ERR:  state_r <= ST_ERR;
        default: state_r <= ST_IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  imem_loader_wr u_wr (
    .clk       (clk),
    .reset     (reset),
    .addr_load (addr_load_s),
    .addr_val  (addr_val_s),
    .wr_req    (wr_req_s),
    .wr_data   (wr_data_s),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
  );

endmodule
